// File: rtl/dice_cgra_tid_pipe_mc.sv
// dice_cgra_tid_pipe_mc: per-lane programmable-latency TID delay pipe
// with exact in-flight tracking, global stall and sticky latency-error.
module dice_cgra_tid_pipe_mc #(
    parameter int NUM_CH      = 4,
    parameter int TOTAL_TID   = 512,
    parameter int TID_WIDTH   = $clog2(TOTAL_TID),
    parameter int MAX_LATENCY = 32,
    parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              stall,
    input  logic [NUM_CH-1:0][LAT_W-1:0]      latency,
    input  logic [NUM_CH-1:0]                 in_valid,
    input  logic [NUM_CH-1:0][TID_WIDTH-1:0]  in_tid,
    output logic                              in_ready,
    output logic [NUM_CH-1:0]                 out_valid,
    output logic [NUM_CH-1:0][TID_WIDTH-1:0]  out_tid,
    output logic [NUM_CH-1:0][LAT_W-1:0]      inflight,
    output logic [NUM_CH-1:0]                 empty,
    output logic                              all_empty,
    output logic [NUM_CH-1:0]                 lat_err
);

    localparam int IDX_W = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    logic [NUM_CH-1:0][MAX_LATENCY-1:0]                vld_q, vld_d;
    logic [NUM_CH-1:0][MAX_LATENCY-1:0][TID_WIDTH-1:0] tid_q, tid_d;
    logic [NUM_CH-1:0][LAT_W-1:0]                      cnt_q, cnt_d;
    logic [NUM_CH-1:0][LAT_W-1:0]                      lat_q, lat_d;
    logic [NUM_CH-1:0]                                 err_q, err_d;

    logic [NUM_CH-1:0][LAT_W-1:0] lat_sat;
    logic [NUM_CH-1:0][LAT_W-1:0] lat_eff;
    logic [NUM_CH-1:0][IDX_W-1:0] tap;

    // Clamp a requested latency into the supported 1..MAX_LATENCY range.
    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] x);
        if (x == '0) begin
            return LAT_ONE;
        end else if (x > LAT_MAX) begin
            return LAT_MAX;
        end
        return x;
    endfunction

    // Pick each lane's effective latency and read the output tap.
    always_comb begin
        lat_sat   = '0;
        lat_eff   = '0;
        tap       = '0;
        out_valid = '0;
        out_tid   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lat_sat[c]   = sat_lat(latency[c]);
            lat_eff[c]   = (cnt_q[c] == '0) ? lat_sat[c] : lat_q[c];
            tap[c]       = IDX_W'(lat_eff[c] - LAT_ONE);
            out_valid[c] = vld_q[c][tap[c]] & ~stall;
            out_tid[c]   = tid_q[c][tap[c]];
        end
    end

    // Next-state: clr flushes, stall freezes, otherwise shift and count.
    always_comb begin
        vld_d = vld_q;
        tid_d = tid_q;
        cnt_d = cnt_q;
        lat_d = lat_q;
        err_d = err_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clr) begin
                vld_d[c] = '0;
                cnt_d[c] = '0;
                err_d[c] = 1'b0;
                lat_d[c] = lat_sat[c];
            end else if (!stall) begin
                vld_d[c][0] = in_valid[c];
                tid_d[c][0] = in_tid[c];
                for (int k = 1; k < MAX_LATENCY; k++) begin
                    vld_d[c][k] = vld_q[c][k-1] & (LAT_W'(k) < lat_eff[c]);
                    tid_d[c][k] = tid_q[c][k-1];
                end
                unique case ({in_valid[c], out_valid[c]})
                    2'b10: begin
                        if (cnt_q[c] != LAT_MAX) begin
                            cnt_d[c] = cnt_q[c] + LAT_ONE;
                        end
                    end
                    2'b01: begin
                        if (cnt_q[c] != '0) begin
                            cnt_d[c] = cnt_q[c] - LAT_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
                if (cnt_q[c] == '0) begin
                    lat_d[c] = lat_sat[c];
                end else if (lat_sat[c] != lat_q[c]) begin
                    err_d[c] = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            tid_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                lat_q[c] <= LAT_ONE;
            end
        end else begin
            vld_q <= vld_d;
            tid_q <= tid_d;
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            err_q <= err_d;
        end
    end

    // Status flags derived directly from the counters.
    always_comb begin
        empty = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = (cnt_q[c] == '0);
        end
    end

    assign in_ready  = ~stall;
    assign inflight  = cnt_q;
    assign all_empty = &empty;
    assign lat_err   = err_q;

endmodule

// File: doc/dice_cgra_tid_pipe_mc.md
# dice_cgra_tid_pipe_mc

Multi-channel thread-ID latency pipe for the DICE CGRA subsystem. Each of NUM_CH lanes delays a (valid, TID) token by its own programmable latency and tracks an exact in-flight count. The block adds a global stall, empty-gated latency reprogramming and a sticky latency-change error flag. It sits beside the CGRA datapath and tags results with their originating thread; the dispatch/retire logic uses its empty flags to decide when a kernel has drained.

## Interface
Parameters:
- NUM_CH, 4: number of independent lanes.
- TOTAL_TID, 512: thread-ID space.
- TID_WIDTH, $clog2(TOTAL_TID): TID bits.
- MAX_LATENCY, 32: deepest supported delay, in cycles; must be >= 1.
- LAT_W, $clog2(MAX_LATENCY+1): width of latency and count fields.

Ports:
- clk  in  1  clock. The block has one clock.
- rst_n  in  1  reset. Synchronous and active-low.
- clr  in  1  flush all lanes.
- stall  in  1  freeze every lane.
- latency  in  [NUM_CH-1:0][LAT_W-1:0]  requested delay per lane.
- in_valid  in  [NUM_CH-1:0]  token valid.
- in_tid  in  [NUM_CH-1:0][TID_WIDTH-1:0]  token TID.
- in_ready  out  1  equals !stall.
- out_valid  out  [NUM_CH-1:0]  delayed token valid.
- out_tid  out  [NUM_CH-1:0][TID_WIDTH-1:0]  delayed TID.
- inflight  out  [NUM_CH-1:0][LAT_W-1:0]  number of valid tokens held in the lane.
- empty  out  [NUM_CH-1:0]  inflight==0.
- all_empty  out  1  AND of all empty bits.
- lat_err  out  [NUM_CH-1:0]  sticky error: latency was changed while the lane was busy.

## Operation
Latency saturation:
- sat(x) = 1 if x==0.
- sat(x) = MAX_LATENCY if x > MAX_LATENCY.
- otherwise sat(x) = x.

Effective latency:
- Each lane holds a register lat_q.
- lat_eff = (inflight==0) ? sat(latency) : lat_q.
- lat_q <= sat(latency) on every non-stalled edge where inflight==0. This includes the edge at which the first token enters.

Storage:
- Each lane has a shift register of MAX_LATENCY stages.
- Stage 0 loads {in_valid, in_tid}; stage k loads stage k-1.
- The valid bit of any stage k >= lat_eff is forced to 0, so tokens past the tap can never reappear when latency later grows.
- out_valid / out_tid are taken from stage lat_eff-1.
- out_valid is gated to 0 while stall=1.

Counter (per lane, saturating at 0 and MAX_LATENCY):
- in_valid & !out_valid: +1.
- !in_valid & out_valid: -1.
- both or neither: hold.

Latency error:
- lat_err[c] sets when inflight!=0, stall=0 and sat(latency)!=lat_q.
- It clears only on reset or clr.
- lat_q is unchanged in that case; the lane keeps its old latency.

Priority:
- rst_n low > clr > stall > normal shift.
- clr:
  - zeroes all valid bits, inflight and lat_err.
  - loads lat_q <= sat(latency).
  - drops any in_valid presented that cycle.
- stall:
  - all stages, inflight, lat_q and lat_err hold.
  - in_valid is ignored, i.e. the token is dropped. Upstream must observe in_ready.
- Lanes are fully independent apart from clk, rst_n, clr and stall.

## Timing
- Reset values:
  - all stage valid bits 0, out_valid 0, out_tid 0 (TID bits are also cleared).
  - inflight 0, empty all 1, all_empty 1, lat_err 0, in_ready = !stall.
  - lat_q = 1.
- A token accepted at edge t (in_valid=1, stall=0) with lat_eff=L drives out_valid=1 from edge t+L-1 until edge t+L. It is visible for exactly one cycle, L cycles after it was presented.
- Each stall cycle adds exactly one cycle to the delay of every in-flight token.
- inflight updates on the same edge the token is accepted or retired. empty is combinational from inflight.
- Back-to-back tokens every cycle:
  - inflight reaches L and holds there.
  - the output stream is identical to the input stream shifted by L.
- The maximum in-flight count is MAX_LATENCY, which fits in LAT_W bits without wrap.
- Reset or clr in the middle of operation discards all tokens. The following cycle shows out_valid=0 and empty=1.

## Test plan
- Reset with clr=0, stall=0, latency=5, no inputs -> all outputs hold their reset values; lat_q loads 5 after the first edge.
- Lane0 latency=3, single TID 0x1A5 presented at edge 10 -> out_valid[0]=1 with out_tid[0]=0x1A5 exactly one cycle, three cycles later; inflight[0] goes 1,1,1,0; other lanes stay idle.
- Lane1 latency=MAX_LATENCY (32), 40 consecutive tokens with TIDs 0..39 -> inflight[1] saturates at 32 and never wraps; outputs emerge in order 0..39 starting 32 cycles after the first token; empty[1] rises after the last one.
- Lane2 latency=4, 3 tokens in flight, stall held for 2 cycles -> no out_valid during the stall; tokens presented during the stall are dropped; each surviving token emerges 6 cycles after it was presented.
- Lane3: set latency 2, send 2 tokens, then change latency to 8 while busy -> lat_err[3]=1 and the tokens still exit with latency 2. After draining, send one token -> it exits with latency 8 and no ghost tokens appear. clr clears lat_err.
- latency=0 and latency=40 on any lane -> these behave as 1 and 32 respectively; clr asserted with tokens in flight -> everything is empty next cycle and no out_valid appears afterwards.
